// File: rtl/sw_alloc.sv
// Switch allocator: five outputs, each arbitrated round-robin among the inputs
// naming it; a won output stays locked to its owner until that owner's tail or request drop.
module sw_alloc #(
    parameter int ROUTERID = 0
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [4:0]  req,
    input  logic [14:0] port,
    input  logic [4:0]  tail,
    input  logic [4:0]  avail,
    output logic [24:0] grt,
    output logic [4:0]  busy,
    output logic [4:0]  perr
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e     state_q [5];
    state_e     state_d [5];
    logic [2:0] owner_q [5];
    logic [2:0] owner_d [5];
    logic [2:0] ptr_q   [5];
    logic [2:0] ptr_d   [5];

    logic [4:0] owns;        // owns[i]: input i currently holds some output
    logic [4:0] cand [5];    // cand[o][i]: input i competes for output o
    logic [4:0] found;
    logic [2:0] win  [5];
    logic [7:0] req_ext;
    logic [7:0] tail_ext;

    // ROUTERID only tags the instance for trace; it never reaches the logic.
    if (ROUTERID >= 0) begin : g_router_id
    end

    assign req_ext  = {3'b000, req};
    assign tail_ext = {3'b000, tail};

    always_comb begin
        perr = '0;
        owns = '0;
        for (int i = 0; i < 5; i++) begin
            perr[i] = req[i] && (port[3*i +: 3] >= 3'd5);
            for (int o = 0; o < 5; o++) begin
                if (state_q[o] == LOCKED && owner_q[o] == 3'(i)) begin
                    owns[i] = 1'b1;
                end
            end
        end
        for (int o = 0; o < 5; o++) begin
            cand[o] = '0;
            for (int i = 0; i < 5; i++) begin
                cand[o][i] = req[i] && (port[3*i +: 3] == 3'(o)) && !owns[i];
            end
        end
    end

    // Scan ptr, ptr+1, ... modulo 5 and take the first candidate.
    always_comb begin
        logic [3:0] idx;
        found = '0;
        idx   = '0;
        for (int o = 0; o < 5; o++) begin
            win[o] = '0;
            for (int k = 0; k < 5; k++) begin
                idx = {1'b0, ptr_q[o]} + 4'(k);
                if (idx >= 4'd5) begin
                    idx = idx - 4'd5;
                end
                for (int j = 0; j < 5; j++) begin
                    if (!found[o] && cand[o][j] && (4'(j) == idx)) begin
                        found[o] = 1'b1;
                        win[o]   = 3'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            case (state_q[o])
                IDLE: begin
                    if (avail[o] && found[o]) begin
                        state_d[o] = LOCKED;
                        owner_d[o] = win[o];
                        ptr_d[o]   = (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
                    end
                end
                LOCKED: begin
                    // Release at this edge; no re-arbitration until the next one.
                    if (!req_ext[owner_q[o]] || tail_ext[owner_q[o]]) begin
                        state_d[o] = IDLE;
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    always_comb begin
        grt  = '0;
        busy = '0;
        for (int o = 0; o < 5; o++) begin
            busy[o] = (state_q[o] == LOCKED);
            for (int i = 0; i < 5; i++) begin
                grt[5*i + o] = (state_q[o] == LOCKED) && (owner_q[o] == 3'(i));
            end
        end
    end

endmodule

// File: doc/sw_alloc.md
SW_ALLOC -- requirements
Module: sw_alloc

Interface
REQ-001 The block SHALL have parameter ROUTERID, default 0, router identifier for debug/trace only, with no functional effect.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, named as follows:
- clk  in  1  clock; all state updates on rising edge.
- rst_  in  1  synchronous active-low reset.
REQ-003 The block SHALL have the following data ports:
- req  in  5  req[i]=1: input channel i requests its target output port.
- port  in  15  {port_4..port_0}, 3 bits each; target output of input i (valid 0..4).
- tail  in  5  tail[i]=1: input i is transferring its tail flit this cycle.
- avail  in  5  avail[o]=1: output channel o can accept a new packet.
- grt  out  25  grt[5*i+o]=1: input i granted output o (feeds crossbar grant bus grt_i[o]).
- busy  out  5  busy[o]=1: output o is locked to an owner.
- perr  out  5  perr[i]=1: input i requested with port value 5..7.

Function
REQ-004 The block SHALL contain, per output o, a 1-bit state (IDLE/LOCKED), a 3-bit owner register and a 3-bit round-robin pointer ptr_o in range 0..4.
REQ-005 Input i SHALL be a candidate for output o when req[i]=1 and port_i==o.
REQ-006 A request with port_i>=5 SHALL never be a candidate; perr[i] SHALL be combinational req[i]&&(port_i>=5).
REQ-007 IDLE -> LOCKED: when output o is IDLE, avail[o]=1 and at least one candidate exists at edge t:
- state_o becomes LOCKED.
- owner_o becomes the first candidate scanning ptr_o, ptr_o+1, ... modulo 5.
- ptr_o becomes (winner+1) mod 5; 4 wraps to 0.
REQ-008 In IDLE with avail[o]=0 or no candidate, state_o, owner_o and ptr_o SHALL hold.
REQ-009 LOCKED -> IDLE: at an edge where req[owner_o]=0, or tail[owner_o]=1, the output SHALL return to IDLE; otherwise it holds LOCKED.
REQ-010 While LOCKED, changes of port_owner, avail[o] or other requests SHALL NOT revoke the lock.
REQ-011 grt[5*i+o] SHALL be combinational from registered state only: (state_o==LOCKED && owner_o==i).
REQ-012 Grant latency SHALL be 1 cycle: request present before edge t produces grant visible after edge t.
REQ-013 After release at edge t, grant SHALL drop after edge t; no arbitration occurs at edge t, and the earliest re-grant of that output is after edge t+1 (one-cycle bubble).
REQ-014 Each input SHALL hold at most one grant, since it names one port. If an input already owns output a and requests a different output b, it SHALL NOT be a candidate for b until it owns no output.
REQ-015 busy[o] SHALL equal (state_o==LOCKED).
REQ-016 Arbitration for the five outputs SHALL be independent and simultaneous in the same cycle.

Reset
REQ-017 With rst_=0 at a rising edge, the block SHALL set all state_o=IDLE, owner_o=0 and ptr_o=0.
REQ-018 After such an edge, grt=0 and busy=0, including when reset arrives mid-lock.
REQ-019 tail, req and avail SHALL be ignored at reset edges.
REQ-020 The first grant after reset deasserts SHALL require a further edge with rst_=1.

Verification
REQ-021 Single request: req=5'b00100, port_2=1, avail=5'b11111, edge t -> after t grt[11]=1, busy=5'b00010, ptr_1=3.
REQ-022 Contention and round-robin:
- After reset, req[0], req[3] both target port 4 -> input 0 granted (grt[4]=1).
- Then tail[0]=1 -> grt[4]=0 after that edge.
- Next edge grants input 3 (grt[19]=1); ptr_4=4.
REQ-023 Wrap-around: ptr_4=4 with inputs 0 and 4 requesting port 4 -> input 4 wins (grt[24]), ptr_4=0; after its tail and the bubble, input 0 wins (grt[4]).
REQ-024 avail gating: avail[2]=0 with a candidate for port 2 -> no grant, busy[2]=0. Dropping avail[2] while LOCKED keeps grant. req[owner]=0 releases the lock at the next edge.
REQ-025 Invalid port plus reset mid-lock:
- port_1=6, req[1]=1 -> perr=5'b00010 and no grt bit set for input 1.
- rst_=0 while output 0 is LOCKED -> grt=0, busy=0 after that edge.
